circuit8_seq: RTL
=================

Name: circuit8_seq

Overview:
- Sequential, start/done-handshaked counterpart of the combinational circuit8 datapath.
- Computes z = ((a mod c) == zero) ? (a - 1) : (c + 1).
- The single-cycle mod is replaced by an iterative restoring remainder unit, one bit per clock.
- Used where a 64-bit combinational modulo cannot close timing; driven by an upstream controller that issues Start and waits for Done.

Parameters:
- DATAWIDTH, 64, operand and result width in bits (unsigned arithmetic throughout).

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous, active-low reset.
- Start  input  1  request; sampled only in state WAIT.
- a  input  DATAWIDTH  dividend / decrement operand; captured when Start is accepted.
- c  input  DATAWIDTH  divisor / increment operand; captured when Start is accepted.
- zero  input  DATAWIDTH  comparand for the remainder; captured when Start is accepted.
- Done  output  1  one-cycle pulse; z is valid from this cycle onward.
- z  output  DATAWIDTH  result register; holds its value until the next Done.

Behaviour:
- Reset (Rst low, asynchronous): state = WAIT, z = 0, Done = 0, count = 0, internal registers = 0.
- Reset mid-operation aborts the job; no Done is produced.
- States: WAIT, DIV, OUT.
- WAIT:
  - Done = 0 unless just leaving OUT.
  - On an edge with Start = 1: capture a, c, zero into ra, rc, rz; set shift register D = a, remainder R = 0 (DATAWIDTH+1 bits), count = 0; go to DIV.
- DIV, per edge:
  - R = {R[DATAWIDTH-1:0], D[DATAWIDTH-1]}, then D = D << 1.
  - If R >= rc, then R = R - rc.
  - count increments.
  - After the iteration with count == DATAWIDTH-1, go to OUT. DIV therefore lasts exactly DATAWIDTH edges.
- OUT, one edge:
  - z <= (R[DATAWIDTH-1:0] == rz) ? ra - 1 : rc + 1.
  - Done <= 1; go to WAIT.
  - Done drops on the following edge.
- Latency: Start sampled at edge 0; Done high in the cycle after edge DATAWIDTH+1 (65 for the default width). Throughput: one job per DATAWIDTH+2 cycles.
- Back-to-back: Start = 1 in the cycle Done is high is accepted; that cycle is WAIT.
- Start while in DIV or OUT is ignored, not queued.
- Input changes after capture have no effect.
- Arithmetic rules:
  - a - 1 and c + 1 wrap modulo 2^DATAWIDTH (0 - 1 = all ones; all ones + 1 = 0).
  - Comparison is unsigned and full-width.
- Divide by zero (rc = 0): every R >= 0 test succeeds with zero subtracted, so the remainder equals ra. No special-case logic; same latency.

Optional Feature:
- Macro: CIRCUIT8_SEQ_DIVZERO_FLAG_EN.
- When defined:
  - Adds output port DivZero (1 bit), registered.
  - DivZero is set in OUT to (rc == 0) and held with z until the next Done; reset value 0.
  - z is computed exactly as without the macro.
- When undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Basic equal path: reset, Start with a=100, c=10, zero=0 -> Done pulses exactly 65 cycles after the Start edge for one cycle; z=99.
- Not-equal path: a=101, c=10, zero=0 -> z=11. Then a=7, c=3, zero=1 -> remainder 1 matches -> z=6.
- Wrap and divide-by-zero:
  - a=0, c=0, zero=0 -> remainder 0 -> z=0xFFFF_FFFF_FFFF_FFFF; DivZero=1 if macro on.
  - a=5, c=0xFFFF_FFFF_FFFF_FFFF, zero=0 -> remainder 5 -> z=0.
- Handshake:
  - Pulse Start again at cycles 10 and 64 of a busy job -> ignored; exactly one Done; z from the first operands.
  - Start asserted during the Done cycle -> second job accepted; second Done 65 cycles later.
- Input isolation: change a, c, zero every cycle after the Start edge -> z matches the captured values only.
- Reset mid-op: drop Rst at cycle 30 of a job -> z=0, Done=0 immediately (asynchronous); after release no Done until a new Start; new job completes correctly.

Source files
------------

// File: rtl/circuit8_seq_if.sv
// Start/Done request bus for circuit8_seq: operands in, registered result out.
// DivZero exists only when CIRCUIT8_SEQ_DIVZERO_FLAG_EN is defined.
interface circuit8_seq_if #(
   parameter int DATAWIDTH = 64
);
   logic                 Start;
   logic [DATAWIDTH-1:0] a;
   logic [DATAWIDTH-1:0] c;
   logic [DATAWIDTH-1:0] zero;
   logic                 Done;
   logic [DATAWIDTH-1:0] z;
`ifdef CIRCUIT8_SEQ_DIVZERO_FLAG_EN
   logic                 DivZero;

   modport master (output Start, a, c, zero, input Done, z, DivZero);
   modport slave  (input Start, a, c, zero, output Done, z, DivZero);
`else
   modport master (output Start, a, c, zero, input Done, z);
   modport slave  (input Start, a, c, zero, output Done, z);
`endif
endinterface

// File: rtl/circuit8_seq.sv
// Sequential circuit8: z = ((a mod c) == zero) ? a - 1 : c + 1, using a one-bit-per-clock
// restoring remainder unit. Optional DivZero flag under CIRCUIT8_SEQ_DIVZERO_FLAG_EN.
module circuit8_seq #(
   parameter int DATAWIDTH = 64
) (
   input logic            Clk,
   input logic            Rst,
   circuit8_seq_if.slave  bus
);

   localparam int CNT_W = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;

   typedef enum logic [1:0] {
      WAIT = 2'd0,
      DIV  = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t               state, stateNext;
   logic [DATAWIDTH-1:0] ra, rc, rz;
   logic [DATAWIDTH-1:0] d;
   logic [DATAWIDTH-1:0] r;
   logic [CNT_W-1:0]     count;
   logic [DATAWIDTH-1:0] zReg;
   logic                 doneReg;
   logic                 lastIter;

   // The remainder register only needs DATAWIDTH bits: after each restore it is below rc,
   // so the extra bit exists only in the shifted trial value.
   logic [DATAWIDTH:0]   rShift;
   logic [DATAWIDTH-1:0] rDiff;
   logic                 rGeq;
   logic [DATAWIDTH-1:0] rNext;

   function automatic logic [DATAWIDTH-1:0] selectResult(
      input logic [DATAWIDTH-1:0] remVal,
      input logic [DATAWIDTH-1:0] opA,
      input logic [DATAWIDTH-1:0] opC,
      input logic [DATAWIDTH-1:0] cmpVal
   );
      return (remVal == cmpVal) ? opA - DATAWIDTH'(1) : opC + DATAWIDTH'(1);
   endfunction

   assign rShift   = {r, d[DATAWIDTH-1]};
   assign rDiff    = rShift[DATAWIDTH-1:0] - rc;
   assign rGeq     = (rShift >= {1'b0, rc});
   assign rNext    = rGeq ? rDiff : rShift[DATAWIDTH-1:0];
   assign lastIter = (count == CNT_W'(DATAWIDTH - 1));

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) state <= WAIT;
      else      state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      unique case (state)
         WAIT:    if (bus.Start) stateNext = DIV;
         DIV:     if (lastIter)  stateNext = OUT;
         OUT:     stateNext = WAIT;
         default: stateNext = WAIT;
      endcase
   end

`ifdef CIRCUIT8_SEQ_DIVZERO_FLAG_EN
   logic divZeroReg;
   assign bus.DivZero = divZeroReg;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst)              divZeroReg <= 1'b0;
      else if (state == OUT) divZeroReg <= (rc == '0);
   end
`endif

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         ra      <= '0;
         rc      <= '0;
         rz      <= '0;
         d       <= '0;
         r       <= '0;
         count   <= '0;
         zReg    <= '0;
         doneReg <= 1'b0;
      end else begin
         unique case (state)
            WAIT: begin
               doneReg <= 1'b0;
               if (bus.Start) begin
                  ra    <= bus.a;
                  rc    <= bus.c;
                  rz    <= bus.zero;
                  d     <= bus.a;
                  r     <= '0;
                  count <= '0;
               end
            end
            DIV: begin
               r     <= rNext;
               d     <= d << 1;
               count <= count + CNT_W'(1);
            end
            OUT: begin
               zReg    <= selectResult(r, ra, rc, rz);
               doneReg <= 1'b1;
            end
            default: doneReg <= 1'b0;
         endcase
      end
   end

   assign bus.Done = doneReg;
   assign bus.z    = zReg;

endmodule
